// File: rtl/trng_harvest_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : trng_harvest_ctrl
//  Purpose  : Controls a metastability-based TRNG sampling core. It starts the
//             launch oscillator and throws away the first raw bits while the
//             oscillator settles. It then packs raw bits MSB-first into words
//             and offers each word on a valid/ready handshake. An optional
//             repetition-count health test can be compiled in; it locks the
//             block into FAULT until software clears the failure.
//  Build    : define TRNG_HEALTH_TEST_EN to compile in the repetition-count
//             health test. Without it, health_fail is tied low and clr_fail
//             is ignored.
//  Ports    : clk_in      - single clock, rising edge
//             rst_n       - asynchronous active-low reset
//             enable      - level request to harvest continuously
//             raw_bit     - registered entropy bit from the sampling core
//             osc_en      - oscillator run gate (1 = running)
//             rnd_data    - harvested word (first collected bit at MSB)
//             rnd_valid   - rnd_data is valid
//             rnd_ready   - consumer accepts the word
//             busy        - controller is not idle
//             health_fail - sticky health-test failure flag
//             clr_fail    - clears FAULT and health_fail
//  Revision : 1.0 - initial release
// ============================================================================
module trng_harvest_ctrl #(
  parameter int WORD_W        = 32,
  parameter int SETTLE_CYCLES = 4,
  parameter int REP_LIMIT     = 16
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              raw_bit,
  output logic              osc_en,
  output logic [WORD_W-1:0] rnd_data,
  output logic              rnd_valid,
  input  logic              rnd_ready,
  output logic              busy,
  output logic              health_fail,
  input  logic              clr_fail
);

  localparam int               CNT_W       = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LAST_IDX    = CNT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] FULL_CNT    = CNT_W'(WORD_W);
  localparam logic [7:0]       SETTLE_LOAD = 8'(SETTLE_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_COLLECT = 3'd2,
    ST_HOLD    = 3'd3,
    ST_FAULT   = 3'd4
  } state_t;

  state_t            state;
  logic [7:0]        settle_cnt;
  logic [CNT_W-1:0]  bit_cnt;
  logic [WORD_W-1:0] shift_reg;
  logic [WORD_W-1:0] next_word;

  // Word as it will look once this cycle's raw bit is shifted in.
  assign next_word = {shift_reg[WORD_W-2:0], raw_bit};
  assign busy      = (state != ST_IDLE);

`ifdef TRNG_HEALTH_TEST_EN
  localparam logic [7:0] REP_MAX = 8'(REP_LIMIT);

  logic [7:0] run_cnt;
  logic       last_bit;
  logic       health_trip;

  // The run length already reached with earlier bits decides the trip. The
  // bit that arrives in the same cycle as the trip is dropped with the word.
  assign health_trip = (run_cnt == REP_MAX);
`else
  logic [8:0] unused_cfg;
  assign unused_cfg  = {clr_fail, 8'(REP_LIMIT)};
  assign health_fail = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      osc_en     <= 1'b0;
      rnd_valid  <= 1'b0;
      rnd_data   <= '0;
      settle_cnt <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
`ifdef TRNG_HEALTH_TEST_EN
      health_fail <= 1'b0;
      run_cnt     <= '0;
      last_bit    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable) begin
            state      <= ST_SETTLE;
            osc_en     <= 1'b1;
            settle_cnt <= SETTLE_LOAD;
`ifdef TRNG_HEALTH_TEST_EN
            run_cnt    <= '0;
`endif
          end
        end

        ST_SETTLE: begin
          if (!enable) begin
            state      <= ST_IDLE;
            osc_en     <= 1'b0;
            settle_cnt <= '0;
          end else if (settle_cnt == 8'd1) begin
            // The counter holds the number of settle cycles still to go,
            // including this one.
            state      <= ST_COLLECT;
            settle_cnt <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
          end else begin
            settle_cnt <= settle_cnt - 8'd1;
          end
        end

        ST_COLLECT: begin
`ifdef TRNG_HEALTH_TEST_EN
          if (health_trip) begin
            state       <= ST_FAULT;
            osc_en      <= 1'b0;
            health_fail <= 1'b1;
            bit_cnt     <= '0;
            shift_reg   <= '0;
          end else
`endif
          if (!enable) begin
            state     <= ST_IDLE;
            osc_en    <= 1'b0;
            bit_cnt   <= '0;
            shift_reg <= '0;
          end else begin
            shift_reg <= next_word;
`ifdef TRNG_HEALTH_TEST_EN
            last_bit  <= raw_bit;
            if ((run_cnt == 8'd0) || (raw_bit != last_bit)) begin
              run_cnt <= 8'd1;
            end else if (run_cnt != 8'hFF) begin
              run_cnt <= run_cnt + 8'd1;
            end
`endif
            if (bit_cnt == LAST_IDX) begin
              state     <= ST_HOLD;
              rnd_data  <= next_word;
              rnd_valid <= 1'b1;
              bit_cnt   <= FULL_CNT;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

        ST_HOLD: begin
          // The word is not retracted when enable drops. Only the handshake
          // leaves HOLD.
          if (rnd_ready) begin
            rnd_valid <= 1'b0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            if (enable) begin
              state <= ST_COLLECT;
            end else begin
              state  <= ST_IDLE;
              osc_en <= 1'b0;
            end
          end
        end

        ST_FAULT: begin
`ifdef TRNG_HEALTH_TEST_EN
          if (clr_fail) begin
            state       <= ST_IDLE;
            health_fail <= 1'b0;
          end
`else
          state <= ST_IDLE;
`endif
        end

        default: begin
          state     <= ST_IDLE;
          osc_en    <= 1'b0;
          rnd_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
